// File: rtl/data_path_egress_if.sv
// rtl/data_path_egress_if.sv - handshake bundle between the data path issuer and the egress stream
interface data_path_egress_if #(
  parameter int phit_size = 512
);
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [phit_size-1:0] m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic                 m_axis_tready;

  modport master (
    output in_valid, in_last, m_axis_tready,
    input  in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    input  in_valid, in_last, m_axis_tready,
    output in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/data_path_egress.sv
// rtl/data_path_egress.sv - credit-gated capture of the data path result into an egress FIFO
// Beats are issued against FIFO credit, tracked through a valid/last delay line, then buffered.
module data_path_egress #(
  parameter int latency_pe_a = 1,
  parameter int latency_pe_b = 1,
  parameter int latency_pe_c = 1,
  parameter int latency_pe_d = 1,
  parameter int phit_size    = 512,
  parameter int pipe_latency = 2*latency_pe_a + latency_pe_b + 2*latency_pe_c + latency_pe_d,
  parameter int fifo_depth   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  data_path_egress_if.slave           eg,
  input  logic [phit_size-1:0]        dp_stream_out,
  output logic [$clog2(fifo_depth):0] occupancy,
  output logic                        overflow
);
  localparam int aw = $clog2(fifo_depth);
  localparam int cw = aw + 1;

  typedef logic [phit_size:0] entry_t;

  logic [pipe_latency-1:0] vld_sr_q, vld_sr_d;
  logic [pipe_latency-1:0] last_sr_q, last_sr_d;
  logic                    accept, cap_valid, cap_last;
  logic                    full, push, pop, dec_inflight;
  logic [aw-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cw-1:0]           count_q, count_d, inflight_q, inflight_d;
  logic [cw:0]             credit_used;
  entry_t                  mem_q [fifo_depth];
  entry_t                  wr_entry, head;
  logic                    tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [phit_size-1:0]    tdata_q, tdata_d;
  logic                    overflow_q, overflow_d;

  // Credit counts buffered beats plus those still travelling through the data path.
  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
  assign eg.in_ready = !rst && (credit_used < (cw+1)'(fifo_depth));
  assign accept      = eg.in_valid && eg.in_ready;

  assign cap_valid    = vld_sr_q[pipe_latency-1];
  assign cap_last     = last_sr_q[pipe_latency-1];
  assign full         = (count_q == cw'(fifo_depth));
  assign pop          = tvalid_q && eg.m_axis_tready;
  assign push         = cap_valid && (!full || pop);
  assign dec_inflight = cap_valid && (inflight_q != '0);
  assign wr_entry     = {dp_stream_out, cap_last};

  always_comb begin
    vld_sr_d     = '0;
    last_sr_d    = '0;
    vld_sr_d[0]  = accept;
    last_sr_d[0] = accept && eg.in_last;
    for (int i = 1; i < pipe_latency; i++) begin
      vld_sr_d[i]  = vld_sr_q[i-1];
      last_sr_d[i] = last_sr_q[i-1];
    end
  end

  always_comb begin
    wptr_d     = wptr_q + aw'(push);
    rptr_d     = rptr_q + aw'(pop);
    count_d    = count_q + cw'(push) - cw'(pop);
    inflight_d = inflight_q + cw'(accept) - cw'(dec_inflight);
    overflow_d = overflow_q || (cap_valid && full && !pop);
    // The next head is the slot being written right now only when it lands in an emptying FIFO.
    head       = (push && (rptr_d == wptr_q)) ? wr_entry : mem_q[rptr_d];
    tvalid_d   = (count_d != '0);
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    if (count_d != '0) begin
      tdata_d = head[phit_size:1];
      tlast_d = head[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr_q   <= '0;
      last_sr_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      vld_sr_q   <= vld_sr_d;
      last_sr_q  <= last_sr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wr_entry;
    end
  end

  assign eg.m_axis_tvalid = tvalid_q;
  assign eg.m_axis_tlast  = tlast_q;
  assign eg.m_axis_tdata  = tdata_q;
  assign occupancy        = count_q;
  assign overflow         = overflow_q;
endmodule

// File: tb/tb_data_path_egress.sv
// tb/tb_data_path_egress.sv - directed and streaming checks for data_path_egress
module tb_data_path_egress;
  localparam int w  = 64;
  localparam int l  = 6;
  localparam int d  = 16;
  localparam int cw = w + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [w-1:0] in_data;
  logic [w-1:0] dp_stream_out;
  logic [4:0]   occupancy;
  logic         overflow;
  logic [w-1:0] dp_pipe [l];
  int           errors = 0;
  int           checks = 0;
  int           acc, sent, recv, cyc;
  logic [w:0]   exp_q [$];

  always #5 clk = ~clk;

  data_path_egress_if #(.phit_size(w)) eg ();

  data_path_egress #(
    .phit_size   (w),
    .pipe_latency(l),
    .fifo_depth  (d)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .eg           (eg),
    .dp_stream_out(dp_stream_out),
    .occupancy    (occupancy),
    .overflow     (overflow)
  );

  // Stand-in for the external data path: in_data delayed by pipe_latency cycles.
  always_ff @(posedge clk) begin
    dp_pipe[0] <= in_data;
    for (int i = 1; i < l; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_stream_out = dp_pipe[l-1];

  task automatic check(input string tag, input logic [w:0] got, input logic [w:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    eg.in_valid = 1'b0;
    eg.in_last  = 1'b0;
    in_data     = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    eg.m_axis_tready = 1'b0;
    tick();
    tick();
    check("rst_in_ready",  cw'(eg.in_ready), cw'(0));
    check("rst_tvalid",    cw'(eg.m_axis_tvalid), cw'(0));
    check("rst_tlast",     cw'(eg.m_axis_tlast), cw'(0));
    check("rst_tdata",     cw'(eg.m_axis_tdata), cw'(0));
    check("rst_occupancy", cw'(occupancy), cw'(0));
    check("rst_overflow",  cw'(overflow), cw'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", cw'(eg.in_ready), cw'(1));

    // single beat latency
    eg.m_axis_tready = 1'b1;
    eg.in_valid      = 1'b1;
    eg.in_last       = 1'b1;
    in_data          = 64'hA5A5_A5A5_A5A5_A5A5;
    tick();
    idle();
    for (int k = 1; k <= l + 2; k++) begin
      check($sformatf("lat_tvalid_c%0d", k), cw'(eg.m_axis_tvalid), cw'(k == l + 1));
      if (k == l + 1) begin
        check("lat_tdata", cw'(eg.m_axis_tdata), cw'(64'hA5A5_A5A5_A5A5_A5A5));
        check("lat_tlast", cw'(eg.m_axis_tlast), cw'(1));
      end
      tick();
    end

    // fill with tready low
    eg.m_axis_tready = 1'b0;
    eg.in_valid      = 1'b1;
    acc = 0;
    for (int c = 0; c < d + l + 4; c++) begin
      in_data = 64'h100 + 64'(acc);
      if (eg.in_ready) acc++;
      tick();
    end
    idle();
    check("fill_accepted",  cw'(acc), cw'(d));
    check("fill_in_ready",  cw'(eg.in_ready), cw'(0));
    check("fill_occupancy", cw'(occupancy), cw'(d));
    check("fill_overflow",  cw'(overflow), cw'(0));
    check("fill_head",      cw'(eg.m_axis_tdata), cw'(64'h100));

    // one pop from full, then refill one beat
    eg.m_axis_tready = 1'b1;
    tick();
    eg.m_axis_tready = 1'b0;
    check("pop_occupancy", cw'(occupancy), cw'(d - 1));
    check("pop_in_ready",  cw'(eg.in_ready), cw'(1));
    check("pop_head",      cw'(eg.m_axis_tdata), cw'(64'h101));
    eg.in_valid = 1'b1;
    in_data     = 64'h1AA;
    tick();
    idle();
    check("refill_in_ready", cw'(eg.in_ready), cw'(0));
    for (int k = 1; k < l; k++) tick();
    check("refill_occ_before", cw'(occupancy), cw'(d - 1));
    tick();
    check("refill_occ_full", cw'(occupancy), cw'(d));

    // capture while full and not popping
    force dut.cap_valid = 1'b1;
    tick();
    release dut.cap_valid;
    check("ovf_set",       cw'(overflow), cw'(1));
    check("ovf_occupancy", cw'(occupancy), cw'(d));
    check("ovf_head",      cw'(eg.m_axis_tdata), cw'(64'h101));
    tick();
    tick();
    tick();
    check("ovf_sticky", cw'(overflow), cw'(1));
    rst = 1'b1;
    tick();
    check("ovf_rst_clear",     cw'(overflow), cw'(0));
    check("ovf_rst_occupancy", cw'(occupancy), cw'(0));
    check("ovf_rst_in_ready",  cw'(eg.in_ready), cw'(0));
    check("ovf_rst_tvalid",    cw'(eg.m_axis_tvalid), cw'(0));
    rst = 1'b0;

    // reset with 5 in flight and 3 buffered
    eg.m_axis_tready = 1'b0;
    eg.in_valid      = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_data = 64'h200 + 64'(c);
      tick();
    end
    idle();
    tick();
    check("mid_occupancy", cw'(occupancy), cw'(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    eg.m_axis_tready = 1'b1;
    for (int k = 0; k < l + 4; k++) begin
      check($sformatf("mid_rst_tvalid_c%0d", k), cw'(eg.m_axis_tvalid), cw'(0));
      tick();
    end
    check("mid_rst_occupancy", cw'(occupancy), cw'(0));

    // random streaming
    sent = 0;
    recv = 0;
    cyc  = 0;
    while ((sent < 1000 || recv < 1000) && cyc < 20000) begin
      eg.in_valid      = (sent < 1000) && ($urandom_range(0, 1) == 1);
      in_data          = 64'h1000 + 64'(sent);
      eg.in_last       = ((sent % 7) == 6);
      eg.m_axis_tready = (sent >= 1000) ? 1'b1 : ($urandom_range(0, 1) == 1);
      if (eg.m_axis_tvalid && eg.m_axis_tready) begin
        check("stream_pop_expected", cw'(exp_q.size() != 0), cw'(1));
        if (exp_q.size() != 0) begin
          check($sformatf("stream_beat_%0d", recv), {eg.m_axis_tdata, eg.m_axis_tlast}, exp_q.pop_front());
        end
        recv++;
      end
      if (eg.in_valid && eg.in_ready) begin
        exp_q.push_back({in_data, eg.in_last});
        sent++;
      end
      tick();
      cyc++;
    end
    idle();
    check("stream_sent",      cw'(sent), cw'(1000));
    check("stream_recv",      cw'(recv), cw'(1000));
    check("stream_overflow",  cw'(overflow), cw'(0));
    check("stream_occupancy", cw'(occupancy), cw'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
